fetch_prefetch_buffer: RTL and testbench

Instruction fetch stage with a small prefetch FIFO. It sits between the instruction memory and the IF/ID pipeline latch, and it owns the fetch PC. It keeps fetching while decode is stalled, until the buffer is full. It presents the oldest buffered instruction and its PC+4 to the IF/ID latch, and discards all buffered work on a branch/jump redirect.

---
 rtl/fetch_prefetch_buffer_pkg.sv | 14 +
 rtl/fetch_prefetch_buffer_if.sv | 43 ++++
 rtl/fetch_prefetch_buffer_fifo_mem.sv | 62 ++++++
 rtl/fetch_prefetch_buffer.sv | 67 ++++++
 tb/tb_fetch_prefetch_buffer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared types and constants for the fetch prefetch buffer.
// Entry layout, PC step and bubble instruction.
package fetch_prefetch_buffer_pkg;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int          DEF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch bus: imem port, control from the pipeline,
// and the head-entry view presented to the IF/ID latch.
interface fetch_prefetch_buffer_if
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  logic [31:0]            imem_adr;
  logic [31:0]            imem_data;
  logic                   stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [31:0]            instruction_IF;
  logic [31:0]            pc_adder_IF;
  logic                   valid_IF;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  imem_adr,
    input  instruction_IF,
    input  pc_adder_IF,
    input  valid_IF,
    input  count
  );

  modport slave (
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output imem_adr,
    output instruction_IF,
    output pc_adder_IF,
    output valid_IF,
    output count
  );

endinterface

// File: rtl/fetch_prefetch_buffer_fifo_mem.sv
// Circular entry store with natural-wrap pointers.
// Flush clears pointers and occupancy; entries are left as-is.
module prefetch_fifo_mem
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers/occupancy; flush wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: owns fetch PC, fills the prefetch FIFO
// while decode stalls, flushes on redirect.
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   next_pc;
  logic          push, pop, not_empty;
  logic [CW-1:0] count;
  fetch_entry_t  head, wdata;

  assign next_pc   = fetch_pc_q + PC_INC;
  assign not_empty = (count != '0);
  assign pop       = not_empty & ~bus.stall & ~bus.redirect;
  assign push      = ~bus.redirect & ((count < CW'(DEPTH)) | pop);
  assign wdata     = '{instr: bus.imem_data, pc4: next_pc};

  prefetch_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  // Fetch PC: redirect target, else advance on each push
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect)  fetch_pc_d = bus.redirect_pc;
    else if (push)     fetch_pc_d = next_pc;
  end

  // Fetch PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_pc_q <= RESET_PC;
    else      fetch_pc_q <= fetch_pc_d;
  end

  // Head view; bubble when empty so IF/ID loads a NOP
  always_comb begin
    bus.instruction_IF = NOP_INSTR;
    bus.pc_adder_IF    = '0;
    bus.valid_IF       = 1'b0;
    if (not_empty) begin
      bus.instruction_IF = head.instr;
      bus.pc_adder_IF    = head.pc4;
      bus.valid_IF       = 1'b1;
    end
  end

  assign bus.imem_adr = fetch_pc_q;
  assign bus.count    = count;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer.
// Consumed entries are checked by a scoreboard monitor.
module tb_fetch_prefetch_buffer;
  import fetch_prefetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_entry_t exp_q[$];

  fetch_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = 32'h2000_0000 | bus.imem_adr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = 32'h2000_0000 | pc;
    e.pc4   = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name,
                          input logic [31:0] pc);
    chk({name, "_instr"}, bus.instruction_IF, 32'h2000_0000 | pc);
    chk({name, "_pc4"}, bus.pc_adder_IF, pc + 32'd4);
  endtask

  // Scoreboard monitor: compare every consumed head entry
  always @(negedge clk) begin
    if (rst && bus.valid_IF && !bus.stall && !bus.redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got pc4 %h want none @%0t",
                 bus.pc_adder_IF, $time);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("pop_instr", bus.instruction_IF, e.instr);
        chk("pop_pc4", bus.pc_adder_IF, e.pc4);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    #2;
    chk("rst_valid", 32'(bus.valid_IF), 32'd0);
    chk("rst_instr", bus.instruction_IF, 32'd0);
    chk("rst_pc4", bus.pc_adder_IF, 32'd0);
    chk("rst_adr", bus.imem_adr, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);

    // Free run: heads 0x0, 0x4, 0x8
    tick();
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    rst = 1'b1;
    @(negedge clk);
    chk("empty_valid", 32'(bus.valid_IF), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("run_count", 32'(bus.count), 32'd1);
      chk("run_valid", 32'(bus.valid_IF), 32'd1);
    end

    // Stall six cycles: fill to DEPTH, PC freezes
    tick();
    bus.stall = 1'b1;
    for (int p = 'hC; p <= 'h1C; p += 4) expect_pc(32'(p));
    @(negedge clk);
    chk_head("stall_head0", 32'hC);
    repeat (6) tick();
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_adr", bus.imem_adr, 32'h1C);
    chk_head("stall_head6", 32'hC);

    // One-edge release while full: pop and push together
    bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    chk("popush_count", 32'(bus.count), 32'd4);
    chk("popush_adr", bus.imem_adr, 32'h20);
    chk_head("popush_head", 32'h10);

    // Release: four back-to-back pops
    tick();
    bus.stall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("drain_valid", 32'(bus.valid_IF), 32'd1);
      chk("drain_count", 32'(bus.count), 32'd4);
    end

    // Redirect from full, then build count 3
    tick();
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("rd1_count", 32'(bus.count), 32'd0);
    chk("rd1_adr", bus.imem_adr, 32'h200);
    repeat (3) tick();
    chk("c3_count", 32'(bus.count), 32'd3);

    // Redirect to 0x100 with count 3 under stall
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("rd2_count", 32'(bus.count), 32'd0);
    chk("rd2_valid", 32'(bus.valid_IF), 32'd0);
    chk("rd2_instr", bus.instruction_IF, 32'd0);
    chk("rd2_pc4", bus.pc_adder_IF, 32'd0);
    chk("rd2_adr", bus.imem_adr, 32'h100);
    @(negedge clk);
    chk_head("rd2_tgt", 32'h100);
    chk("rd2_tcount", 32'(bus.count), 32'd1);

    // Back-to-back redirects: last wins
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_pc = 32'h400;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("b2b_adr", bus.imem_adr, 32'h400);
    chk("b2b_count", 32'(bus.count), 32'd0);
    tick();
    tick();
    chk("pre_rst_count", 32'(bus.count), 32'd2);

    // Async reset pulse mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid_IF), 32'd0);
    chk("arst_instr", bus.instruction_IF, 32'd0);
    chk("arst_pc4", bus.pc_adder_IF, 32'd0);
    chk("arst_adr", bus.imem_adr, 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    #4;
    rst = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    tick();
    bus.stall = 1'b0;
    @(negedge clk);
    chk("restart_adr", bus.imem_adr, 32'h4);

    // PC wrap at top of address space
    tick();
    tick();
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("wrap_adr0", bus.imem_adr, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(bus.valid_IF), 32'd0);
    @(negedge clk);
    chk("wrap_adr1", bus.imem_adr, 32'h0);
    @(negedge clk);
    tick();
    bus.stall = 1'b1;
    @(negedge clk);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
